cond_eval_unit: RTL and testbench
=================================

Name: cond_eval_unit

Overview:
- Consumer end of the ALU flag interface: holds the architectural NZCV flag register and records the writes produced by the flag ALU.
- Resolves 4-bit condition-code queries against those flags through a valid/ready request/response handshake.
- Tracks in-flight flag-setting operations and stalls queries until the flags they depend on have retired; forwards a same-cycle flag write.
- Sits between the ALU writeback and branch/predication logic.

Parameters:
MAX_PEND, 4, maximum outstanding flag-setting ops tracked (>=1)
TAG_W, 4, width of the opaque tag carried from request to response

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard outstanding flag ops and any held response
flag_issue  input  1  pulse: a flag-setting op was issued
issue_ready  output  1  a flag-setting op may issue this cycle
flag_we  input  1  pulse: a flag-setting op retires, nzcv_in valid
nzcv_in  input  4  {n,z,c,v} from flag ALU
nzcv_q  output  4  current flag register {n,z,c,v}
req_valid  input  1  condition query valid
req_ready  output  1  query accepted when high with req_valid
req_cond  input  4  condition code
req_tag  input  TAG_W  query tag
resp_valid  output  1  result valid
resp_ready  input  1  downstream accepts result
resp_taken  output  1  condition result
resp_tag  output  TAG_W  tag of the query
err_pend  output  1  sticky pending-counter over/underflow

Behaviour:
- Reset (async, rst_n low): nzcv_q=0000, pend count=0, resp_valid=0, resp_taken=0, resp_tag=0, err_pend=0. A reset asserted mid-operation drops everything.
- Flag register: on flag_we, nzcv_q <= nzcv_in next edge.
- Pending counter, width clog2(MAX_PEND+1):
  - next = count + flag_issue - flag_we.
  - issue_ready = (count<MAX_PEND) | flag_we.
  - flag_issue while !issue_ready: count unchanged, err_pend<=1.
  - flag_we with count==0 and !flag_issue: count stays 0, err_pend<=1.
  - Simultaneous issue+retire: count unchanged.
- Forwarding: eff_flags = flag_we ? nzcv_in : nzcv_q; eff_pend = count - flag_we (no underflow below 0).
- req_ready = (eff_pend==0) & (!resp_valid | resp_ready) & !flush.
  - A query accepted in the same cycle as flag_issue is older than that op: it uses eff_flags and is not stalled by it.
- Evaluation on accept, result registered, latency 1 (resp_valid next cycle). Codes:
  - 0 EQ z; 1 NE !z; 2 CS c; 3 CC !c; 4 MI n; 5 PL !n; 6 VS v; 7 VC !v
  - 8 HI c&!z; 9 LS !c|z; A GE n==v; B LT n!=v; C GT !z&(n==v); D LE z|(n!=v)
  - E AL 1; F 1 (reserved, treated as always)
- Output register: holds resp_* stable while resp_valid & !resp_ready. Accept with resp_ready high gives back-to-back throughput of 1/cycle.
- flush (synchronous, priority over everything except reset):
  - count<=0; resp_valid<=0; no query accepted.
  - A flag_we in the same cycle is still written to nzcv_q.
  - flag_issue in the same cycle is ignored.
  - err_pend is unaffected; it clears only by reset.

Decomposition:
- Shared package: cond_e enum (EQ..AL, NV) 4-bit; nzcv_t packed struct {n,z,c,v}, which the flag ALU output bundling also uses.
- Sub-module: cond_decode (combinational nzcv_t + cond_e -> taken), reusable by the predication path.

Test Plan:
- Reset -> all outputs 0. flag_we nzcv_in=0100 (Z) then query EQ tag 3 -> next cycle resp_valid=1, taken=1, tag=3; NE -> taken=0.
- Sweep all 16 codes over all 16 nzcv values -> taken matches table (e.g. nzcv=1001: GE=1, LT=0, GT=1, HI=0).
- flag_issue, query GT held valid: req_ready=0 for 3 cycles. flag_we nzcv_in=0000 on cycle 4 -> accepted that cycle via forwarding, taken=1, nzcv_q=0000 next cycle.
- resp_ready low 5 cycles with second query pending -> resp_* stable, req_ready=0. resp_ready high -> second result the following cycle, no loss.
- MAX_PEND=4: 5 consecutive flag_issue -> issue_ready=0 on the 5th, err_pend=1, count stays 4. 4 flag_we -> count 0. Further flag_we -> err_pend stays 1.
- 2 flag_issue, then flush with a held response -> resp_valid=0 and count=0 next cycle; query accepted the cycle after.

Source files
------------

// File: rtl/cond_eval_unit_pkg.sv
// Shared types for the condition evaluation path: condition codes and the NZCV flag bundle.
package cond_eval_unit_pkg;

  typedef enum logic [3:0] {
    CondEq = 4'h0,
    CondNe = 4'h1,
    CondCs = 4'h2,
    CondCc = 4'h3,
    CondMi = 4'h4,
    CondPl = 4'h5,
    CondVs = 4'h6,
    CondVc = 4'h7,
    CondHi = 4'h8,
    CondLs = 4'h9,
    CondGe = 4'hA,
    CondLt = 4'hB,
    CondGt = 4'hC,
    CondLe = 4'hD,
    CondAl = 4'hE,
    CondNv = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/cond_eval_unit_if.sv
// Condition query request/response handshake between branch logic and the evaluator.
interface cond_eval_unit_if #(
  parameter int unsigned TAG_W = 4
) ();

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_cond;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_taken;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_cond, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_taken, resp_tag
  );

  modport slave (
    input  req_valid, req_cond, req_tag, resp_ready,
    output req_ready, resp_valid, resp_taken, resp_tag
  );

endinterface

// File: rtl/cond_decode.sv
// Combinational condition-code decode against a set of NZCV flags.
module cond_decode
  import cond_eval_unit_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  taken
);

  always_comb begin
    taken = 1'b1;
    unique case (cond)
      CondEq: taken = flags.z;
      CondNe: taken = ~flags.z;
      CondCs: taken = flags.c;
      CondCc: taken = ~flags.c;
      CondMi: taken = flags.n;
      CondPl: taken = ~flags.n;
      CondVs: taken = flags.v;
      CondVc: taken = ~flags.v;
      CondHi: taken = flags.c & ~flags.z;
      CondLs: taken = ~flags.c | flags.z;
      CondGe: taken = (flags.n == flags.v);
      CondLt: taken = (flags.n != flags.v);
      CondGt: taken = ~flags.z & (flags.n == flags.v);
      CondLe: taken = flags.z | (flags.n != flags.v);
      CondAl, CondNv: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_eval_unit.sv
// NZCV flag register with in-flight flag-op tracking; resolves condition queries once flags settle.
module cond_eval_unit
  import cond_eval_unit_pkg::*;
#(
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned TAG_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       flag_issue,
  output logic       issue_ready,
  input  logic       flag_we,
  input  logic [3:0] nzcv_in,
  output logic [3:0] nzcv_q,
  output logic       err_pend,
  cond_eval_unit_if.slave bus
);

  localparam int unsigned     CntW   = $clog2(MAX_PEND + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_PEND);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  eff_pend;
  nzcv_t            flags_q;
  nzcv_t            eff_flags;
  logic             resp_valid_q;
  logic             resp_taken_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic             err_q;
  logic             taken;
  logic             accept;
  logic             issue_ok;

  assign issue_ready = (cnt_q < MaxCnt) | flag_we;
  assign issue_ok    = flag_issue & issue_ready;

  // A retiring write is visible to a query in the same cycle.
  assign eff_flags = flag_we ? nzcv_t'(nzcv_in) : flags_q;
  assign eff_pend  = (flag_we && cnt_q != '0) ? cnt_q - OneCnt : cnt_q;

  assign bus.req_ready = (eff_pend == '0) & (~resp_valid_q | bus.resp_ready) & ~flush;
  assign accept        = bus.req_valid & bus.req_ready;

  cond_decode u_cond_decode (
    .flags (eff_flags),
    .cond  (cond_e'(bus.req_cond)),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_tag_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      if (flag_we) flags_q <= nzcv_t'(nzcv_in);
      if (flush) begin
        cnt_q        <= '0;
        resp_valid_q <= 1'b0;
      end else begin
        if (flag_issue && !issue_ready) err_q <= 1'b1;
        if (flag_we && !flag_issue && cnt_q == '0) err_q <= 1'b1;
        if (issue_ok && !flag_we) begin
          cnt_q <= cnt_q + OneCnt;
        end else if (flag_we && !issue_ok && cnt_q != '0) begin
          cnt_q <= cnt_q - OneCnt;
        end
        if (accept) begin
          resp_valid_q <= 1'b1;
          resp_taken_q <= taken;
          resp_tag_q   <= bus.req_tag;
        end else if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
        end
      end
    end
  end

  assign nzcv_q         = flags_q;
  assign err_pend       = err_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_taken = resp_taken_q;
  assign bus.resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Self-checking bench for cond_eval_unit: vector table, full code sweep, corner sequences, random.
module tb_cond_eval_unit;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       flag_issue;
  logic       issue_ready;
  logic       flag_we;
  logic [3:0] nzcv_in;
  logic [3:0] nzcv_q;
  logic       err_pend;

  int n_chk  = 0;
  int n_fail = 0;

  cond_eval_unit_if #(.TAG_W(4)) bus ();

  cond_eval_unit #(.MAX_PEND(4), .TAG_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .flag_issue  (flag_issue),
    .issue_ready (issue_ready),
    .flag_we     (flag_we),
    .nzcv_in     (nzcv_in),
    .nzcv_q      (nzcv_q),
    .err_pend    (err_pend),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] nzcv;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  // ARM-style encoding: even codes test a base condition, odd codes its inverse.
  function automatic logic ref_taken(input logic [3:0] f, input logic [3:0] cond);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond[3:1] == 3'd7) return 1'b1;
    return base ^ cond[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; flag_issue = 0; flag_we = 0; nzcv_in = 0;
    bus.req_valid = 0; bus.req_cond = 0; bus.req_tag = 0; bus.resp_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // Load flags (issue+retire together so no pending change) and query; optionally in one cycle.
  task automatic query(input logic [3:0] f, input logic [3:0] cond, input logic [3:0] tag,
                       input logic exp, input bit fwd, input string name);
    tick();
    flag_issue = 1; flag_we = 1; nzcv_in = f;
    if (!fwd) begin
      tick();
      flag_issue = 0; flag_we = 0; nzcv_in = ~f;
    end
    bus.req_valid = 1; bus.req_cond = cond; bus.req_tag = tag; bus.resp_ready = 1;
    #1 chk({name, " req_ready"}, 32'(bus.req_ready), 1);
    tick();
    idle();
    chk({name, " resp_valid"}, 32'(bus.resp_valid), 1);
    chk({name, " resp_taken"}, 32'(bus.resp_taken), 32'(exp));
    chk({name, " resp_tag"}, 32'(bus.resp_tag), 32'(tag));
    chk({name, " nzcv_q"}, 32'(nzcv_q), 32'(f));
  endtask

  vec_t vecs[14];

  // Random-phase model state
  int         m_cnt;
  logic [3:0] m_nzcv;
  logic       m_rv, m_taken, m_err;
  logic [3:0] m_tag;

  initial begin
    vecs[0]  = '{4'b1001, 4'hA, 1'b1};
    vecs[1]  = '{4'b1001, 4'hB, 1'b0};
    vecs[2]  = '{4'b1001, 4'hC, 1'b1};
    vecs[3]  = '{4'b1001, 4'h8, 1'b0};
    vecs[4]  = '{4'b0100, 4'h0, 1'b1};
    vecs[5]  = '{4'b0100, 4'h1, 1'b0};
    vecs[6]  = '{4'b0110, 4'h8, 1'b0};
    vecs[7]  = '{4'b0010, 4'h8, 1'b1};
    vecs[8]  = '{4'b0110, 4'h9, 1'b1};
    vecs[9]  = '{4'b1000, 4'h4, 1'b1};
    vecs[10] = '{4'b0001, 4'h6, 1'b1};
    vecs[11] = '{4'b0000, 4'hF, 1'b1};
    vecs[12] = '{4'b1000, 4'hA, 1'b0};
    vecs[13] = '{4'b1101, 4'hD, 1'b1};

    do_reset();
    chk("reset resp_valid", 32'(bus.resp_valid), 0);
    chk("reset resp_taken", 32'(bus.resp_taken), 0);
    chk("reset resp_tag", 32'(bus.resp_tag), 0);
    chk("reset nzcv_q", 32'(nzcv_q), 0);
    chk("reset err_pend", 32'(err_pend), 0);
    chk("reset issue_ready", 32'(issue_ready), 1);
    chk("reset req_ready", 32'(bus.req_ready), 1);

    // Hand-derived vector table, half via forwarding, half via the register
    for (int i = 0; i < 14; i++)
      query(vecs[i].nzcv, vecs[i].cond, 4'(i), vecs[i].exp, i[0], $sformatf("vec%0d", i));

    // Full sweep against the model
    for (int f = 0; f < 16; f++)
      for (int c = 0; c < 16; c++)
        query(4'(f), 4'(c), 4'(f + c), ref_taken(4'(f), 4'(c)), (c % 3) == 0,
              $sformatf("sweep f%0h c%0h", f, c));

    // Stall on a pending op, then accept via a forwarded retire
    do_reset();
    query(4'b1111, 4'hE, 4'd0, 1'b1, 1'b1, "preload");
    tick();
    flag_issue = 1;
    tick();
    flag_issue = 0;
    bus.req_valid = 1; bus.req_cond = 4'hC; bus.req_tag = 4'd5;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall req_ready c%0d", k), 32'(bus.req_ready), 0);
      tick();
    end
    flag_we = 1; nzcv_in = 4'b0000;
    #1 chk("fwd req_ready", 32'(bus.req_ready), 1);
    tick();
    idle();
    chk("fwd resp_valid", 32'(bus.resp_valid), 1);
    chk("fwd resp_taken", 32'(bus.resp_taken), 1);
    chk("fwd resp_tag", 32'(bus.resp_tag), 5);
    chk("fwd nzcv_q", 32'(nzcv_q), 0);

    // Backpressure: response held, second query waits
    tick();
    bus.resp_ready = 0; bus.req_valid = 1; bus.req_cond = 4'h0; bus.req_tag = 4'd1;
    #1 chk("bp first req_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_cond = 4'h1; bus.req_tag = 4'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp req_ready c%0d", k), 32'(bus.req_ready), 0);
      chk($sformatf("bp resp_valid c%0d", k), 32'(bus.resp_valid), 1);
      chk($sformatf("bp resp_taken c%0d", k), 32'(bus.resp_taken), 0);
      chk($sformatf("bp resp_tag c%0d", k), 32'(bus.resp_tag), 1);
      tick();
    end
    bus.resp_ready = 1;
    #1 chk("bp release req_ready", 32'(bus.req_ready), 1);
    tick();
    idle();
    chk("bp second resp_valid", 32'(bus.resp_valid), 1);
    chk("bp second resp_taken", 32'(bus.resp_taken), 1);
    chk("bp second resp_tag", 32'(bus.resp_tag), 2);
    tick();
    chk("bp drained resp_valid", 32'(bus.resp_valid), 0);

    // Pending counter overflow / underflow
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      flag_issue = 1;
      #1 chk($sformatf("ovf issue_ready i%0d", k), 32'(issue_ready), 32'(k < 4));
    end
    tick();
    flag_issue = 0;
    chk("ovf err_pend", 32'(err_pend), 1);
    #1 chk("ovf count held at max", 32'(issue_ready), 0);
    for (int k = 0; k < 4; k++) begin
      flag_we = 1; nzcv_in = 4'b0000;
      #1 chk($sformatf("drain req_ready r%0d", k), 32'(bus.req_ready), 32'(k == 3));
      tick();
    end
    flag_we = 0;
    #1;
    chk("drained issue_ready", 32'(issue_ready), 1);
    chk("drained req_ready", 32'(bus.req_ready), 1);
    flag_we = 1;
    tick();
    flag_we = 0;
    #1;
    chk("unf err_pend", 32'(err_pend), 1);
    chk("unf count stays 0", 32'(issue_ready), 1);
    chk("unf req_ready", 32'(bus.req_ready), 1);

    // Flush with a held response and two pending ops
    do_reset();
    tick();
    bus.resp_ready = 0; flag_issue = 1;
    bus.req_valid = 1; bus.req_cond = 4'h0; bus.req_tag = 4'd7;
    #1 chk("flush pre req_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 0;
    tick();
    flag_issue = 0;
    chk("flush held resp_valid", 32'(bus.resp_valid), 1);
    flush = 1; flag_we = 1; nzcv_in = 4'b1010;
    #1 chk("flush req_ready", 32'(bus.req_ready), 0);
    tick();
    flush = 0; flag_we = 0;
    chk("flush resp_valid", 32'(bus.resp_valid), 0);
    chk("flush nzcv_q", 32'(nzcv_q), 32'hA);
    chk("flush err_pend", 32'(err_pend), 0);
    bus.req_valid = 1; bus.req_cond = 4'hB; bus.req_tag = 4'd9; bus.resp_ready = 1;
    #1 chk("post flush req_ready", 32'(bus.req_ready), 1);
    tick();
    idle();
    chk("post flush resp_valid", 32'(bus.resp_valid), 1);
    chk("post flush resp_taken", 32'(bus.resp_taken), 1);
    chk("post flush resp_tag", 32'(bus.resp_tag), 9);

    // Random traffic against a cycle-level behavioural model
    do_reset();
    m_cnt = 0; m_nzcv = 0; m_rv = 0; m_taken = 0; m_err = 0; m_tag = 0;
    for (int i = 0; i < 2000; i++) begin
      logic e_ir, e_rr, acc;
      logic [3:0] eff;
      int pend_w, nc;
      tick();
      chk("rnd nzcv_q", 32'(nzcv_q), 32'(m_nzcv));
      chk("rnd resp_valid", 32'(bus.resp_valid), 32'(m_rv));
      chk("rnd err_pend", 32'(err_pend), 32'(m_err));
      if (m_rv) begin
        chk("rnd resp_taken", 32'(bus.resp_taken), 32'(m_taken));
        chk("rnd resp_tag", 32'(bus.resp_tag), 32'(m_tag));
      end
      flag_issue = ($urandom_range(0, 2) == 0);
      flag_we = ($urandom_range(0, 2) == 0);
      nzcv_in = 4'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      bus.req_valid = $urandom_range(0, 1) == 1;
      bus.req_cond = 4'($urandom);
      bus.req_tag = 4'($urandom);
      bus.resp_ready = ($urandom_range(0, 9) < 7);
      #1;
      eff = flag_we ? nzcv_in : m_nzcv;
      pend_w = (flag_we && m_cnt > 0) ? m_cnt - 1 : m_cnt;
      e_ir = (m_cnt < 4) || flag_we;
      e_rr = (pend_w == 0) && (!m_rv || bus.resp_ready) && !flush;
      chk("rnd issue_ready", 32'(issue_ready), 32'(e_ir));
      chk("rnd req_ready", 32'(bus.req_ready), 32'(e_rr));
      acc = bus.req_valid && e_rr;
      if (flag_we) m_nzcv = nzcv_in;
      if (flush) begin
        m_cnt = 0;
        m_rv = 0;
      end else begin
        if (flag_issue && !e_ir) m_err = 1;
        nc = m_cnt + int'(flag_issue && e_ir) - int'(flag_we);
        if (nc < 0) begin
          nc = 0;
          m_err = 1;
        end
        m_cnt = nc;
        if (acc) begin
          m_rv = 1;
          m_taken = ref_taken(eff, bus.req_cond);
          m_tag = bus.req_tag;
        end else if (bus.resp_ready) begin
          m_rv = 0;
        end
      end
    end

    // Asynchronous reset mid-operation
    tick();
    idle();
    rst_n = 0;
    #1;
    chk("async rst resp_valid", 32'(bus.resp_valid), 0);
    chk("async rst nzcv_q", 32'(nzcv_q), 0);
    chk("async rst err_pend", 32'(err_pend), 0);
    chk("async rst issue_ready", 32'(issue_ready), 1);
    rst_n = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
